// File: rtl/axis_cmd_arbiter.sv
// Two-requester arbiter for the axis_wb_master command port. Forwards one complete
// 0xA1/0xA2 frame at a time. Routes the response back to the owner until rsp_tlast,
// and aborts the grant after TIMEOUT_CYCLES idle cycles.
module axis_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_tdata,
  input  logic       s0_tvalid,
  output logic       s0_tready,
  input  logic [7:0] s1_tdata,
  input  logic       s1_tvalid,
  output logic       s1_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  input  logic [7:0] rsp_tdata,
  input  logic       rsp_tvalid,
  output logic       rsp_tready,
  input  logic       rsp_tlast,
  output logic [7:0] r0_tdata,
  output logic       r0_tvalid,
  input  logic       r0_tready,
  output logic       r0_tlast,
  output logic [7:0] r1_tdata,
  output logic       r1_tvalid,
  input  logic       r1_tready,
  output logic       r1_tlast,
  output logic [1:0] grant,
  output logic       timeout_err
);

  localparam logic [7:0]  CmdRead  = 8'hA1;
  localparam logic [7:0]  CmdWrite = 8'hA2;
  localparam logic [23:0] TmoLimit = 24'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StHdr, StWdata, StWaitRsp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;           // 0: requester 0, 1: requester 1
  logic        last_grant_q, last_grant_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;       // header bytes still to forward
  logic        is_write_q, is_write_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [17:0] wcnt_q, wcnt_d;             // write data bytes still to forward
  logic [23:0] tmo_q, tmo_d;
  logic        timeout_err_q, timeout_err_d;

  logic s0_cmd, s1_cmd, any_cmd, pick, m_hs, rsp_hs;

  assign s0_cmd  = s0_tvalid && (s0_tdata == CmdRead || s0_tdata == CmdWrite);
  assign s1_cmd  = s1_tvalid && (s1_tdata == CmdRead || s1_tdata == CmdWrite);
  assign any_cmd = s0_cmd || s1_cmd;
  // On a tie the requester not granted last wins.
  assign pick    = (s0_cmd && s1_cmd) ? ~last_grant_q : s1_cmd;
  assign m_hs    = m_tvalid && m_tready;
  assign rsp_hs  = rsp_tvalid && rsp_tready;

  assign timeout_err = timeout_err_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      hdr_cnt_q     <= 3'd0;
      is_write_q    <= 1'b0;
      len_hi_q      <= 8'h00;
      wcnt_q        <= 18'd0;
      tmo_q         <= 24'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      hdr_cnt_q     <= hdr_cnt_d;
      is_write_q    <= is_write_d;
      len_hi_q      <= len_hi_d;
      wcnt_q        <= wcnt_d;
      tmo_q         <= tmo_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state: frame parsing, completion and timeout abort.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    hdr_cnt_d     = hdr_cnt_q;
    is_write_d    = is_write_q;
    len_hi_d      = len_hi_q;
    wcnt_d        = wcnt_q;
    tmo_d         = tmo_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmo_d = 24'd0;
        if (m_hs) begin
          state_d    = StHdr;
          owner_d    = pick;
          hdr_cnt_d  = 3'd6;
          is_write_d = (m_tdata == CmdWrite);
        end
      end
      StHdr: begin
        if (m_hs) begin
          hdr_cnt_d = hdr_cnt_q - 3'd1;
          if (hdr_cnt_q == 3'd2) len_hi_d = m_tdata;
          if (hdr_cnt_q == 3'd1) begin
            if (!is_write_q || {len_hi_q, m_tdata} == 16'd0) begin
              state_d = StWaitRsp;
            end else begin
              state_d = StWdata;
              wcnt_d  = {len_hi_q, m_tdata, 2'b00};
            end
          end
        end
      end
      StWdata: begin
        if (m_hs) begin
          wcnt_d = wcnt_q - 18'd1;
          if (wcnt_q == 18'd1) state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (rsp_hs && rsp_tlast) begin
          state_d      = StIdle;
          last_grant_d = owner_q;
        end
      end
    endcase
    if (state_q != StIdle) begin
      if (m_hs || rsp_hs) begin
        tmo_d = 24'd0;
      end else if (tmo_q + 24'd1 == TmoLimit) begin
        state_d       = StIdle;
        timeout_err_d = 1'b1;
        last_grant_d  = owner_q;
        tmo_d         = 24'd0;
      end else begin
        tmo_d = tmo_q + 24'd1;
      end
    end
  end

  // Outputs: combinational muxing of the command and response streams.
  always_comb begin
    m_tvalid   = 1'b0;
    m_tdata    = 8'h00;
    s0_tready  = 1'b0;
    s1_tready  = 1'b0;
    rsp_tready = 1'b0;
    r0_tvalid  = 1'b0;
    r1_tvalid  = 1'b0;
    r0_tdata   = rsp_tdata;
    r1_tdata   = rsp_tdata;
    r0_tlast   = rsp_tlast;
    r1_tlast   = rsp_tlast;
    grant      = 2'b00;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          rsp_tready = 1'b1;
          m_tvalid   = any_cmd;
          m_tdata    = pick ? s1_tdata : s0_tdata;
          // Non-command bytes are filler and are consumed to resync.
          s0_tready  = s0_cmd ? (!pick && m_tready) : s0_tvalid;
          s1_tready  = s1_cmd ? (pick && m_tready) : s1_tvalid;
        end
        StHdr, StWdata: begin
          m_tvalid  = owner_q ? s1_tvalid : s0_tvalid;
          m_tdata   = owner_q ? s1_tdata : s0_tdata;
          s0_tready = !owner_q && m_tready;
          s1_tready = owner_q && m_tready;
        end
        StWaitRsp: begin
          s0_tready = !owner_q;
          s1_tready = owner_q;
        end
      endcase
      if (state_q != StIdle) begin
        grant      = owner_q ? 2'b10 : 2'b01;
        rsp_tready = owner_q ? r1_tready : r0_tready;
        r0_tvalid  = !owner_q && rsp_tvalid;
        r1_tvalid  = owner_q && rsp_tvalid;
      end
    end
  end

endmodule

// File: tb/tb_axis_cmd_arbiter.sv
// Cycle-exact directed bench for axis_cmd_arbiter: per-cycle vector tables of
// inputs and hand-computed outputs, plus sequences for reset and timeout.
module tb_axis_cmd_arbiter;

  logic       clk, rst;
  logic [7:0] s0_tdata, s1_tdata, m_tdata, rsp_tdata, r0_tdata, r1_tdata;
  logic       s0_tvalid, s0_tready, s1_tvalid, s1_tready, m_tvalid, m_tready;
  logic       rsp_tvalid, rsp_tready, rsp_tlast;
  logic       r0_tvalid, r0_tready, r0_tlast, r1_tvalid, r1_tready, r1_tlast;
  logic [1:0] grant;
  logic       timeout_err;

  axis_cmd_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
    .rsp_tlast(rsp_tlast),
    .r0_tdata(r0_tdata), .r0_tvalid(r0_tvalid), .r0_tready(r0_tready), .r0_tlast(r0_tlast),
    .r1_tdata(r1_tdata), .r1_tvalid(r1_tvalid), .r1_tready(r1_tready), .r1_tlast(r1_tlast),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s0/s1/m: {valid, data}; rsp: {valid, last, data};
  // fl: {s0_tready, s1_tready, r0_tvalid, r1_tvalid, rsp_tready, timeout_err}
  typedef struct {
    logic [8:0] s0;
    logic [8:0] s1;
    logic       mr;
    logic [9:0] rsp;
    logic [1:0] g;
    logic [8:0] m;
    logic [5:0] fl;
  } vec_t;

  localparam logic [9:0] NR = 10'h000;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [8:0] s0, input logic [8:0] s1, input logic mr,
                              input logic [9:0] rsp, input logic [1:0] g, input logic [8:0] m,
                              input logic [5:0] fl);
    vec_t v;
    v.s0 = s0; v.s1 = s1; v.mr = mr; v.rsp = rsp; v.g = g; v.m = m; v.fl = fl;
    return v;
  endfunction

  // Apply one row just after a falling edge, compare, then advance to the next falling edge.
  task automatic step(input vec_t v, input string name, input int idx);
    logic [25:0] act, exp;
    s0_tvalid  = v.s0[8];  s0_tdata  = v.s0[7:0];
    s1_tvalid  = v.s1[8];  s1_tdata  = v.s1[7:0];
    m_tready   = v.mr;
    rsp_tvalid = v.rsp[9]; rsp_tlast = v.rsp[8]; rsp_tdata = v.rsp[7:0];
    #2;
    exp = {v.g, v.m[8], v.m[8] ? v.m[7:0] : 8'h00, v.fl,
           (v.fl[3] || v.fl[2]) ? {v.rsp[7:0], v.rsp[8]} : 9'h000};
    act = {grant, m_tvalid, m_tvalid ? m_tdata : 8'h00,
           s0_tready, s1_tready, r0_tvalid, r1_tvalid, rsp_tready, timeout_err,
           r0_tvalid ? {r0_tdata, r0_tlast} : (r1_tvalid ? {r1_tdata, r1_tlast} : 9'h000)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
    @(negedge clk);
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], name, i);
    tbl.delete();
  endtask

  // n forwarded bytes (taken from the top of h) from requester own; other requester held at oth.
  task automatic push_bytes(input logic [63:0] h, input int n, input bit own,
                            input logic [8:0] oth);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = h[63-8*i -: 8];
      if (!own) tbl.push_back(mk({1'b1, b}, oth, 1'b1, NR, 2'b01, {1'b1, b}, 6'b100010));
      else      tbl.push_back(mk(oth, {1'b1, b}, 1'b1, NR, 2'b10, {1'b1, b}, 6'b010010));
    end
  endtask

  task automatic push_idle();
    tbl.push_back(mk(9'h000, 9'h000, 1'b1, NR, 2'b00, 9'h000, 6'b000010));
  endtask

  logic [8:0] bp [15];

  initial begin
    rst = 1'b1;
    r0_tready = 1'b1; r1_tready = 1'b1;
    s0_tvalid = 1'b0; s0_tdata = 8'h00; s1_tvalid = 1'b0; s1_tdata = 8'h00;
    m_tready = 1'b0; rsp_tvalid = 1'b0; rsp_tdata = 8'h00; rsp_tlast = 1'b0;
    @(negedge clk);
    // Everything quiet while reset is held, even with traffic offered.
    step(mk(9'h1A1, 9'h1A1, 1'b1, 10'h200, 2'b00, 9'h000, 6'b000000), "reset", 0);
    rst = 1'b0;

    // Ties starting at reset exit: s0, then s1, then s0 again.
    tbl.push_back(mk(9'h1A1, 9'h1A1, 1'b1, NR, 2'b00, 9'h1A1, 6'b100010));
    push_bytes(64'h0, 6, 1'b0, 9'h1A1);
    tbl.push_back(mk(9'h000, 9'h1A1, 1'b1, 10'h3E1, 2'b01, 9'h000, 6'b101010));
    tbl.push_back(mk(9'h1A2, 9'h1A1, 1'b1, NR, 2'b00, 9'h1A1, 6'b010010));
    push_bytes(64'h0, 6, 1'b1, 9'h1A2);
    tbl.push_back(mk(9'h1A2, 9'h000, 1'b1, 10'h3E2, 2'b10, 9'h000, 6'b010110));
    tbl.push_back(mk(9'h1A2, 9'h1A1, 1'b1, NR, 2'b00, 9'h1A2, 6'b100010));
    push_bytes(64'h0, 6, 1'b0, 9'h1A1);
    tbl.push_back(mk(9'h000, 9'h000, 1'b1, 10'h3E3, 2'b01, 9'h000, 6'b101010));
    push_idle();
    run_tbl("tie");

    // Read from s0 with trailing filler and a 5-byte response.
    tbl.push_back(mk(9'h1A1, 9'h000, 1'b1, NR, 2'b00, 9'h1A1, 6'b100010));
    push_bytes(64'h0000_1000_0001_0000, 6, 1'b0, 9'h000);
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk((i < 4) ? 9'h100 : 9'h000, 9'h000, 1'b1,
                       {1'b1, i == 4, 8'(8'hC0 + i)}, 2'b01, 9'h000, 6'b101010));
    push_idle();
    run_tbl("read");

    // Write from s1, L=2: 15 command bytes, then filler dropped in WAIT_RSP.
    tbl.push_back(mk(9'h000, 9'h1A2, 1'b1, NR, 2'b00, 9'h1A2, 6'b010010));
    push_bytes(64'h0000_0004_0002_0000, 6, 1'b1, 9'h000);
    push_bytes(64'hD0D1_D2D3_D4D5_D6D7, 8, 1'b1, 9'h000);
    tbl.push_back(mk(9'h000, 9'h133, 1'b1, NR, 2'b10, 9'h000, 6'b010010));
    tbl.push_back(mk(9'h000, 9'h000, 1'b1, 10'h377, 2'b10, 9'h000, 6'b010110));
    push_idle();
    run_tbl("write");

    // Garbage ahead of a command is consumed without reaching the master.
    tbl.push_back(mk(9'h100, 9'h000, 1'b1, NR, 2'b00, 9'h000, 6'b100010));
    tbl.push_back(mk(9'h1FF, 9'h000, 1'b1, NR, 2'b00, 9'h000, 6'b100010));
    tbl.push_back(mk(9'h155, 9'h000, 1'b1, NR, 2'b00, 9'h000, 6'b100010));
    tbl.push_back(mk(9'h1A1, 9'h000, 1'b1, NR, 2'b00, 9'h1A1, 6'b100010));
    push_bytes(64'h2000_0000_0000_0000, 6, 1'b0, 9'h000);
    tbl.push_back(mk(9'h000, 9'h000, 1'b1, 10'h3AB, 2'b01, 9'h000, 6'b101010));
    push_idle();
    run_tbl("garbage");

    // Write L=1 from s0 with m_tready toggling; entries are {m_tready, byte}.
    bp = '{9'h011, 9'h111, 9'h122, 9'h033, 9'h133, 9'h144, 9'h100, 9'h001, 9'h101,
           9'h1D0, 9'h0D1, 9'h1D1, 9'h1D2, 9'h0D3, 9'h1D3};
    tbl.push_back(mk(9'h1A2, 9'h000, 1'b0, NR, 2'b00, 9'h1A2, 6'b000010));
    tbl.push_back(mk(9'h1A2, 9'h000, 1'b1, NR, 2'b00, 9'h1A2, 6'b100010));
    for (int i = 0; i < 15; i++)
      tbl.push_back(mk({1'b1, bp[i][7:0]}, 9'h000, bp[i][8], NR, 2'b01,
                       {1'b1, bp[i][7:0]}, {bp[i][8], 5'b00010}));
    tbl.push_back(mk(9'h1EE, 9'h000, 1'b1, NR, 2'b01, 9'h000, 6'b100010));
    tbl.push_back(mk(9'h000, 9'h000, 1'b1, 10'h35A, 2'b01, 9'h000, 6'b101010));
    push_idle();
    run_tbl("backpressure");

    // Write L=0 from s1: WAIT_RSP right after the 7th byte.
    tbl.push_back(mk(9'h000, 9'h1A2, 1'b1, NR, 2'b00, 9'h1A2, 6'b010010));
    push_bytes(64'h0000_0008_0000_0000, 6, 1'b1, 9'h000);
    tbl.push_back(mk(9'h000, 9'h199, 1'b1, NR, 2'b10, 9'h000, 6'b010010));
    tbl.push_back(mk(9'h000, 9'h000, 1'b1, 10'h301, 2'b10, 9'h000, 6'b010110));
    push_idle();
    run_tbl("write_l0");

    // Timeout: pulse 16 cycles after the last handshake, then s1 is granted.
    tbl.push_back(mk(9'h1A1, 9'h000, 1'b1, NR, 2'b00, 9'h1A1, 6'b100010));
    push_bytes(64'h0000_0000_0001_0000, 6, 1'b0, 9'h000);
    for (int i = 1; i <= 20; i++) begin
      if (i <= 16)      tbl.push_back(mk(9'h000, 9'h000, 1'b1, NR, 2'b01, 9'h000, 6'b100010));
      else if (i == 17) tbl.push_back(mk(9'h000, 9'h000, 1'b1, NR, 2'b00, 9'h000, 6'b000011));
      else              push_idle();
    end
    tbl.push_back(mk(9'h000, 9'h1A1, 1'b1, NR, 2'b00, 9'h1A1, 6'b010010));
    push_bytes(64'h0, 6, 1'b1, 9'h000);
    tbl.push_back(mk(9'h000, 9'h000, 1'b1, 10'h3C9, 2'b10, 9'h000, 6'b010110));
    push_idle();
    run_tbl("timeout");

    // Asynchronous reset mid-header: immediate abort, no timeout pulse.
    step(mk(9'h1A1, 9'h000, 1'b1, NR, 2'b00, 9'h1A1, 6'b100010), "midreset", 0);
    step(mk(9'h112, 9'h000, 1'b1, NR, 2'b01, 9'h112, 6'b100010), "midreset", 1);
    rst = 1'b1;
    step(mk(9'h134, 9'h000, 1'b1, NR, 2'b00, 9'h000, 6'b000000), "midreset", 2);
    step(mk(9'h134, 9'h000, 1'b1, NR, 2'b00, 9'h000, 6'b000000), "midreset", 3);
    rst = 1'b0;
    step(mk(9'h000, 9'h000, 1'b1, NR, 2'b00, 9'h000, 6'b000010), "midreset", 4);
    step(mk(9'h1A1, 9'h1A1, 1'b1, NR, 2'b00, 9'h1A1, 6'b100010), "midreset", 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
